seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: front end for a 4-digit, active-low 7-segment display.
//   - Divides clk into the scan clock slclk, which also clocks the
//     loss-message stage.
//   - Runs the PLAY/LOSS/WIN result FSM with blink timing.
//   - Converts the binary score to BCD with a sequential double-dabble.
//   - Drives the display pins from either the score scan or the
//     loss-stage pattern, through one output register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   lose, win         game events, level-sampled every clk
//   restart           return to PLAY, highest priority
//   score[13:0]       binary score; saturates to 9999 on display
//   loss_seg, loss_an pattern from the loss-message stage
//   slclk             divided scan clock
//   seg[6:0]          segments, active-low, seg[6]=a .. seg[0]=g
//   an[3:0]           anodes, active-low, an[3]=leftmost digit
//   state[1:0]        00=PLAY, 01=LOSS, 10=WIN
module seg_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lose,
  input  logic        win,
  input  logic        restart,
  input  logic [13:0] score,
  input  logic [6:0]  loss_seg,
  input  logic [3:0]  loss_an,
  output logic        slclk,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {PLAY = 2'b00, LOSS = 2'b01, WIN = 2'b10} state_e;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0000001;
      4'd1:    seg_enc = 7'b1001111;
      4'd2:    seg_enc = 7'b0010010;
      4'd3:    seg_enc = 7'b0000110;
      4'd4:    seg_enc = 7'b1001100;
      4'd5:    seg_enc = 7'b0100100;
      4'd6:    seg_enc = 7'b0100000;
      4'd7:    seg_enc = 7'b0001111;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0000100;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  // ---------------- scan divider ----------------
  logic [DW-1:0] div_cnt_q;
  logic          slclk_q;
  logic          div_term, scan_tick;

  assign div_term  = (div_cnt_q == DW'(SCAN_DIV - 1));
  // The cycle whose edge takes slclk 0->1.
  assign scan_tick = div_term & ~slclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      slclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_term ? '0 : div_cnt_q + 1'b1;
      if (div_term) slclk_q <= ~slclk_q;
    end
  end

  // ---------------- BCD converter ----------------
  // The accumulator keeps 15 bits: before the last shift the value is at
  // most 4999, so bit 15 is only ever set by the final shift, and the
  // thousands nibble never needs the add-3 correction.
  logic        cv_busy_q;
  logic [3:0]  cv_cnt_q;
  logic [13:0] cv_bin_q;
  logic [14:0] cv_acc_q;
  logic [15:0] bcd_q;
  logic [11:0] cv_adj;
  logic [15:0] cv_shift;

  always_comb begin
    cv_adj = cv_acc_q[11:0];
    for (int i = 0; i < 3; i++)
      if (cv_acc_q[i*4 +: 4] >= 4'd5) cv_adj[i*4 +: 4] = cv_acc_q[i*4 +: 4] + 4'd3;
    cv_shift = {cv_acc_q[14:12], cv_adj, cv_bin_q[13]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_busy_q <= 1'b0;
      cv_cnt_q  <= '0;
      cv_bin_q  <= '0;
      cv_acc_q  <= '0;
      bcd_q     <= '0;
    end else if (!cv_busy_q) begin
      cv_bin_q  <= (score > 14'd9999) ? 14'd9999 : score;
      cv_acc_q  <= '0;
      cv_cnt_q  <= '0;
      cv_busy_q <= 1'b1;
    end else begin
      cv_acc_q <= cv_shift[14:0];
      cv_bin_q <= {cv_bin_q[12:0], 1'b0};
      cv_cnt_q <= cv_cnt_q + 4'd1;
      if (cv_cnt_q == 4'd13) begin
        bcd_q     <= cv_shift;   // whole result lands at once
        cv_busy_q <= 1'b0;
      end
    end
  end

  // ---------------- result FSM ----------------
  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PLAY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart)                   state_d = PLAY;
    else if (state_q == PLAY) begin
      if (lose)                    state_d = LOSS;
      else if (win)                state_d = WIN;
    end
  end

  // ---------------- blink and digit scan ----------------
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;
  logic [1:0]    digit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      digit_q     <= '0;
    end else begin
      if (scan_tick) digit_q <= digit_q + 2'd1;
      // Held in PLAY; the same branch re-arms it on entry to LOSS/WIN,
      // which can only be entered from PLAY.
      if (state_q == PLAY || state_d == PLAY) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (scan_tick) begin
        if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_q     <= ~blink_q;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- output mux ----------------
  logic [3:0] nib;
  logic       blank;
  logic [6:0] seg_d, seg_q;
  logic [3:0] an_d, an_q;

  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    case (digit_q)
      2'd0:    begin nib = bcd_q[15:12]; blank = (bcd_q[15:12] == 4'd0); end
      2'd1:    begin nib = bcd_q[11:8];  blank = (bcd_q[15:8]  == 8'd0); end
      2'd2:    begin nib = bcd_q[7:4];   blank = (bcd_q[15:4]  == 12'd0); end
      default: begin nib = bcd_q[3:0];   blank = 1'b0; end
    endcase

    seg_d = blank ? 7'b1111111 : seg_enc(nib);
    an_d  = ~(4'b1000 >> digit_q);
    if (state_q != PLAY && !blink_q) begin
      seg_d = 7'b1111111;
      an_d  = 4'b1111;
    end else if (state_q == LOSS) begin
      seg_d = loss_seg;
      an_d  = loss_an;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'b1111111;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign slclk = slclk_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign state = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int SD = 4;
  localparam int BT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lose = 1'b0, win = 1'b0, restart = 1'b0;
  logic [13:0] score = '0;
  logic [6:0]  loss_seg = '0;
  logic [3:0]  loss_an = '0;
  logic        slclk;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  state;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .lose(lose), .win(win), .restart(restart),
    .score(score), .loss_seg(loss_seg), .loss_an(loss_an),
    .slclk(slclk), .seg(seg), .an(an), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string tag = "init";

  // scoreboard entries: {slclk, state, an, seg}
  logic [13:0] exp_q[$];

  // reference model, counted in clk edges since reset release
  int         n;
  logic [1:0] m_state;
  logic       m_blink;
  int         m_cnt;
  logic [1:0] m_digit;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [10:0] disp(input logic [1:0] st, input logic bl,
                                       input logic [1:0] dg, input logic [13:0] sc,
                                       input logic [6:0] ls, input logic [3:0] la);
    int v;
    int dd[4];
    logic blank;
    logic [3:0] onehot;
    v = (int'(sc) > 9999) ? 9999 : int'(sc);
    dd[0] = v / 1000; dd[1] = (v / 100) % 10; dd[2] = (v / 10) % 10; dd[3] = v % 10;
    if (st == 2'b01) return bl ? {la, ls} : 11'h7FF;
    if (st == 2'b10 && !bl) return 11'h7FF;
    blank = 1'b1;
    for (int i = 0; i <= int'(dg); i++) if (dd[i] != 0) blank = 1'b0;
    if (dg == 2'd3) blank = 1'b0;
    onehot = 4'b1000 >> dg;
    return {~onehot, blank ? 7'h7F : enc(dd[dg])};
  endfunction

  task automatic model_reset();
    n = 0; m_state = 2'b00; m_blink = 1'b1; m_cnt = 0; m_digit = 2'd0;
  endtask

  task automatic chk_reset(input string t);
    checks++;
    assert ({slclk, state, an, seg} === {1'b0, 2'b00, 4'hF, 7'h7F}) else begin
      errors++;
      $error("FAIL %s got %h exp %h", t, {slclk, state, an, seg}, {1'b0, 2'b00, 4'hF, 7'h7F});
    end
  endtask

  // One clk: fresh loss pattern, model update at the edge, compare at negedge.
  task automatic step(input bit chk);
    logic [10:0] eo;
    logic [1:0]  ns;
    logic [13:0] got, exp;
    bit          tk;
    loss_seg = 7'($urandom_range(0, 127));
    loss_an  = 4'($urandom_range(0, 15));
    @(posedge clk);
    n++;
    eo = disp(m_state, m_blink, m_digit, score, loss_seg, loss_an);
    tk = (n % 8 == 4);
    ns = m_state;
    if (restart) ns = 2'b00;
    else if (m_state == 2'b00 && lose) ns = 2'b01;
    else if (m_state == 2'b00 && win) ns = 2'b10;
    if (m_state == 2'b00 || ns == 2'b00) begin
      m_blink = 1'b1; m_cnt = 0;
    end else if (tk) begin
      if (m_cnt == BT - 1) begin m_blink = ~m_blink; m_cnt = 0; end
      else m_cnt++;
    end
    if (tk) m_digit = m_digit + 2'd1;
    m_state = ns;
    if (chk) exp_q.push_back({1'((n / 4) % 2), ns, eo});
    @(negedge clk);
    if (chk) begin
      exp = exp_q.pop_front();
      got = {slclk, state, an, seg};
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s n=%0d got %h exp %h", tag, n, got, exp);
      end
    end
  endtask

  task automatic run(input int cyc, input bit chk);
    for (int i = 0; i < cyc; i++) step(chk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second;
    logic prev;
    // reset state
    #1 rst_n = 1'b0;
    #20;
    chk_reset("reset_hold");
    @(negedge clk); rst_n = 1'b1; model_reset();
    tag = "post_reset";
    run(14, 1'b1);

    // asynchronous reset between clk edges
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk_reset("async_reset");
    @(negedge clk); rst_n = 1'b1; model_reset();
    tag = "slclk";
    first = -1; second = -1; prev = 1'b0;
    for (int i = 0; i < 40 && second < 0; i++) begin
      step(1'b1);
      if (slclk && !prev) begin
        if (first < 0) first = n; else second = n;
      end
      prev = slclk;
    end
    checks++;
    assert (first === 4) else begin errors++; $error("FAIL slclk_first_rise got %0d exp %0d", first, 4); end
    checks++;
    assert (second - first === 8) else begin errors++; $error("FAIL slclk_period got %0d exp %0d", second - first, 8); end

    // score scan
    score = 14'd407; run(32, 1'b0);
    tag = "scan_407"; run(40, 1'b1);
    score = 14'd12000; run(32, 1'b0);
    tag = "saturate"; run(40, 1'b1);
    score = 14'd0; run(32, 1'b0);
    tag = "blank_zero"; run(40, 1'b1);

    // simultaneous lose and win
    score = 14'd407; run(32, 1'b0);
    tag = "loss_entry";
    lose = 1'b1; win = 1'b1; step(1'b1);
    lose = 1'b0; win = 1'b0;
    tag = "loss_blink"; run(60, 1'b1);

    // restart wins over lose, then re-enter LOSS
    tag = "restart";
    restart = 1'b1; lose = 1'b1; step(1'b1);
    restart = 1'b0; lose = 1'b0;
    tag = "play_resume"; run(30, 1'b1);
    tag = "loss_reentry";
    lose = 1'b1; step(1'b1); lose = 1'b0;
    run(12, 1'b1);
    restart = 1'b1; step(1'b1); restart = 1'b0;

    // WIN blink, lose ignored
    score = 14'd25; run(32, 1'b0);
    tag = "win_entry";
    win = 1'b1; step(1'b1); win = 1'b0;
    tag = "win_blink"; run(20, 1'b1);
    tag = "win_ignore_lose";
    lose = 1'b1; run(5, 1'b1); lose = 1'b0;
    tag = "win_blink2"; run(30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
